// File: rtl/stream_mux_rr_pkg.sv
// Shared constants and helpers for the round-robin stream multiplexer.
// Holds the mode encodings and the select-width computation.
// No logic lives here.
package stream_mux_rr_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Ceiling log2 for elaboration-time width computation.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v << 1) begin
      r++;
    end
    return r;
  endfunction

  // Channel index width; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index for N_CH requesters.
// Latency: grant is combinational from req; pointer updates on the next edge.
// Backpressure: pointer moves only when advance is asserted by the consumer.
module rr_arbiter
  import stream_mux_rr_pkg::*;
#(
  parameter  int N_CH  = 4,
  localparam int SEL_W = sel_width(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  req,
  input  logic             advance,
  output logic [N_CH-1:0]  grant_oh,
  output logic [SEL_W-1:0] grant_idx,
  output logic             grant_vld
);

  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] ptr_d;

  // First requester at or above ptr wins; otherwise wrap to the lowest requester.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (!grant_vld && req[i] && (i >= int'(ptr_q))) begin
        grant_vld   = 1'b1;
        grant_idx   = SEL_W'(i);
        grant_oh[i] = 1'b1;
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      if (!grant_vld && req[i]) begin
        grant_vld   = 1'b1;
        grant_idx   = SEL_W'(i);
        grant_oh[i] = 1'b1;
      end
    end
  end

  // After an accepted grant, the channel just served becomes lowest priority.
  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (int'(grant_idx) == N_CH - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel stream mux, manual select or round-robin, single registered output stage.
// Latency: 1 cycle input transfer to out_valid; 1 beat/cycle sustained.
// Backpressure: all in_ready drop while a held beat is not accepted downstream.
module stream_mux_rr
  import stream_mux_rr_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int N_CH   = 4,
  localparam int SEL_W  = sel_width(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [N_CH-1:0]          in_valid,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  output logic [N_CH-1:0]          in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  input  logic                     out_ready
);

  logic [N_CH-1:0]   rr_gnt_oh;
  logic [SEL_W-1:0]  rr_gnt_idx;
  logic              rr_gnt_vld;
  logic [N_CH-1:0]   man_gnt_oh;
  logic              gnt_vld;
  logic [SEL_W-1:0]  gnt_idx;
  logic [N_CH-1:0]   gnt_oh;
  logic              load_en;
  logic              xfer;

  logic              out_valid_q;
  logic              out_valid_d;
  logic [DATA_W-1:0] out_data_q;
  logic [DATA_W-1:0] out_data_d;
  logic [SEL_W-1:0]  out_ch_q;
  logic [SEL_W-1:0]  out_ch_d;

  // The arbiter only advances on a real transfer made in round-robin mode.
  rr_arbiter #(
    .N_CH (N_CH)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (in_valid),
    .advance   (xfer && (mode == MODE_RR)),
    .grant_oh  (rr_gnt_oh),
    .grant_idx (rr_gnt_idx),
    .grant_vld (rr_gnt_vld)
  );

  // Pick the grant source; an out-of-range sel simply matches no channel.
  always_comb begin
    man_gnt_oh = '0;
    gnt_vld    = 1'b0;
    gnt_idx    = '0;
    gnt_oh     = '0;
    for (int i = 0; i < N_CH; i++) begin
      if ((sel == SEL_W'(i)) && in_valid[i]) begin
        man_gnt_oh[i] = 1'b1;
      end
    end
    if (mode == MODE_RR) begin
      gnt_vld = rr_gnt_vld;
      gnt_idx = rr_gnt_idx;
      gnt_oh  = rr_gnt_oh;
    end else begin
      gnt_vld = |man_gnt_oh;
      gnt_idx = sel;
      gnt_oh  = man_gnt_oh;
    end
  end

  // Handshake: the output slot is free when empty or being drained this cycle.
  always_comb begin
    load_en  = !out_valid_q || out_ready;
    xfer     = rst_n && load_en && gnt_vld;
    in_ready = xfer ? gnt_oh : '0;
  end

  // Next output state: load on transfer, empty on drain, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_ch_d    = gnt_idx;
      for (int i = 0; i < N_CH; i++) begin
        if (gnt_oh[i]) begin
          out_data_d = in_data[i*DATA_W +: DATA_W];
        end
      end
    end else if (load_en) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 Parameter: DATA_W, default 8, width of each channel's data in bits (range 1..64).
REQ-002 Parameter: N_CH, default 4, number of input channels (range 2..16).
REQ-003 Derived constant: SEL_W = max(1, ceil(log2(N_CH))); it is not user-overridable.
REQ-004 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port: rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-006 Port: mode  in  1  0 = manual select, 1 = round-robin.
REQ-007 Port: sel  in  SEL_W  channel index used in manual mode.
REQ-008 Port: in_valid  in  N_CH  per-channel valid.
REQ-009 Port: in_data  in  N_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
REQ-010 Port: in_ready  out  N_CH  per-channel ready; combinational.
REQ-011 Port: out_valid  out  1  output register holds a beat.
REQ-012 Port: out_data  out  DATA_W  registered data.
REQ-013 Port: out_ch  out  SEL_W  source channel of the current beat.
REQ-014 Port: out_ready  in  1  downstream accept.

Function
REQ-015 Transfer on input i: in_valid[i] && in_ready[i] at a rising edge; output transfer: out_valid && out_ready.
REQ-016 load_en = !out_valid || out_ready; the output register loads only when load_en and a grant exists.
REQ-017 At most one in_ready bit is high in any cycle; in_ready[g] = load_en && grant_valid, for grant g only.
REQ-018 Manual mode: grant = sel when sel < N_CH and in_valid[sel]; otherwise no grant. Other channels are never granted.
REQ-019 Round-robin mode: grant = first i with in_valid[i], searching ptr, ptr+1, ... wrapping modulo N_CH.
REQ-020 ptr updates only on an input transfer in round-robin mode: ptr <= (grant+1) mod N_CH; grant N_CH-1 wraps to 0.
REQ-021 ptr is held in manual mode; switching mode takes effect on the same cycle's arbitration, with no flush.
REQ-022 Latency: 1 cycle from input transfer to out_valid; sustained throughput is 1 beat/cycle when out_ready stays high.
REQ-023 While out_valid && !out_ready, out_valid, out_data, and out_ch hold stable and all in_ready are 0.
REQ-024 Simultaneous output transfer and new load in the same cycle: the register is overwritten with the new beat and out_valid stays 1.
REQ-025 Output transfer with no grant: out_valid <= 0; out_data and out_ch keep their last values.
REQ-026 in_ready does not depend on out_valid of the same cycle's load; there is no combinational path from in_valid to out_valid.

Reset
REQ-027 While rst_n == 0 at a rising edge: out_valid <= 0, out_data <= 0, out_ch <= 0, ptr <= 0.
REQ-028 During reset, in_ready is all-zero; data presented during reset is not captured.
REQ-029 A reset asserted mid-stream discards the held beat. The first grant after release uses ptr = 0.

Structure
REQ-030 A shared package holds the clog2 function and the MODE_MANUAL/MODE_RR constants.
REQ-031 The block contains one sub-module, rr_arbiter (N_CH request in, one-hot grant plus index out, ptr state inside, advance input).
REQ-032 The target size is 120-400 lines of RTL; no memories; all outputs are registered except in_ready.

Verification
REQ-033 Reset: hold rst_n = 0 for 3 cycles with all in_valid = 1 -> out_valid = 0, in_ready = 0, out_data = 0.
REQ-034 RR fairness: all 4 channels valid, with data 0xA0..0xA3, out_ready = 1 -> out_ch sequence is 0,1,2,3,0, one beat per cycle.
REQ-035 RR skip/wrap: only channels 1 and 3 valid, ptr = 2 -> order 3,1,3; channels 0 and 2 in_ready never asserted.
REQ-036 Backpressure: out_ready = 0 for 5 cycles with beat 0x55 held -> output stable, in_ready = 0; when out_ready rises, one transfer and the next beat loads the same cycle.
REQ-037 Manual mode: mode = 0, sel = 2, all valid -> only channel 2 drains. sel = 3 with in_valid[3] = 0 -> out_valid falls after the current beat.
REQ-038 Mid-stream reset: assert rst_n = 0 while out_valid = 1 -> out_valid = 0 next edge; after release, the first grant is channel 0 when all are valid.
